// File: rtl/tlul_periph_arb_pkg.sv
// Shared types and helpers for the peripheral-bus host arbiter.
// Holds the simplified TL-UL channel structs, default sizes and the round-robin pick function.
package tlul_periph_arb_pkg;

   localparam int unsigned MaxHostsDefault       = 2;
   localparam int unsigned MaxOutstandingDefault = 4;
   localparam int unsigned MaxHosts              = 8;
   localparam int unsigned HostIdxMaxW           = 3;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tlul_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tlul_d2h_t;

   typedef enum logic {
      ArbFree = 1'b0,
      ArbLock = 1'b1
   } arb_st_e;

   // First requester at or after ptr, wrapping modulo n; returns ptr when nobody requests.
   function automatic logic [HostIdxMaxW-1:0] rr_pick(input logic [MaxHosts-1:0]    req,
                                                     input logic [HostIdxMaxW-1:0] ptr,
                                                     input int unsigned            n);
      logic [HostIdxMaxW-1:0] pick;
      logic                   found;
      int unsigned            idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < MaxHosts; k++) begin
         idx = (32'(ptr) + k) % n;
         if (k < n && !found && req[idx[HostIdxMaxW-1:0]]) begin
            pick  = idx[HostIdxMaxW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/tlul_periph_host_arb_if.sv
// Bus bundle between the N upstream hosts, the arbiter and the peripheral crossbar.
interface tlul_periph_host_arb_if
   import tlul_periph_arb_pkg::*;
#(
   parameter int unsigned N = MaxHostsDefault
);

   tlul_h2d_t [N-1:0] tl_h_i;
   tlul_d2h_t [N-1:0] tl_h_o;
   tlul_h2d_t         tl_d_o;
   tlul_d2h_t         tl_d_i;

   modport slave (
      input  tl_h_i,
      input  tl_d_i,
      output tl_h_o,
      output tl_d_o
   );

   modport master (
      output tl_h_i,
      output tl_d_i,
      input  tl_h_o,
      input  tl_d_o
   );

endinterface

// File: rtl/tlul_arb_idx_fifo.sv
// In-order FIFO of host indices, one entry per outstanding A beat.
module tlul_arb_idx_fifo #(
   parameter  int unsigned Width = 1,
   parameter  int unsigned Depth = 4,
   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CntW-1:0]  count,
   output logic [Width-1:0] rdata
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             wr_en, rd_en;

   assign full  = (count_q == CntW'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/tlul_periph_host_arb.sv
// Round-robin N:1 TL-UL host arbiter with in-order host-ID tracking for D-channel steering.
//   state   | meaning
//   ArbFree | grant follows the round-robin scan from rr_ptr
//   ArbLock | forwarded A beat stalled; grant held on lock_idx until accepted
module tlul_periph_host_arb
   import tlul_periph_arb_pkg::*;
#(
   parameter  int unsigned N              = MaxHostsDefault,
   parameter  int unsigned MaxOutstanding = MaxOutstandingDefault,
   localparam int unsigned IdxW           = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned CntW           = $clog2(MaxOutstanding) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   tlul_periph_host_arb_if.slave bus,
   output logic [CntW-1:0]       outstanding_o,
   output logic                  err_spurious_o
);

   arb_st_e           st_q, st_d;
   logic [IdxW-1:0]   rr_ptr_q, lock_idx_q;
   logic [IdxW-1:0]   rr_winner, winner, next_ptr, head;
   logic [N-1:0]      req;
   logic              fifo_full, fifo_empty;
   logic              fwd_valid, accept, d_ready, pop;
   tlul_h2d_t         tl_d_o;
   tlul_d2h_t [N-1:0] tl_h_o;

   always_comb begin
      req = '0;
      for (int i = 0; i < N; i++) req[i] = bus.tl_h_i[i].a_valid;
   end

   assign rr_winner = IdxW'(rr_pick(MaxHosts'(req), HostIdxMaxW'(rr_ptr_q), N));
   assign winner    = (st_q == ArbLock) ? lock_idx_q : rr_winner;
   assign next_ptr  = (winner == IdxW'(N - 1)) ? '0 : winner + 1'b1;

   // Outputs are qualified by rst_ni so the bus reads idle the moment reset asserts.
   assign fwd_valid      = rst_ni & req[winner] & ~fifo_full;
   assign accept         = fwd_valid & bus.tl_d_i.a_ready;
   assign d_ready        = rst_ni & (fifo_empty | bus.tl_h_i[head].d_ready);
   assign pop            = bus.tl_d_i.d_valid & d_ready & ~fifo_empty;
   assign err_spurious_o = rst_ni & bus.tl_d_i.d_valid & fifo_empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q       <= ArbFree;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         st_q <= st_d;
         if (st_d == ArbLock) lock_idx_q <= winner;
         if (accept)          rr_ptr_q   <= next_ptr;
      end
   end

   always_comb begin
      st_d = ArbFree;
      if (fwd_valid && !bus.tl_d_i.a_ready) st_d = ArbLock;
   end

   always_comb begin
      tl_d_o         = bus.tl_h_i[winner];
      tl_d_o.a_valid = fwd_valid;
      tl_d_o.d_ready = d_ready;
      for (int i = 0; i < N; i++) begin
         tl_h_o[i]         = bus.tl_d_i;
         tl_h_o[i].a_ready = rst_ni & bus.tl_d_i.a_ready & ~fifo_full & (winner == IdxW'(i));
         tl_h_o[i].d_valid = rst_ni & bus.tl_d_i.d_valid & ~fifo_empty & (head == IdxW'(i));
      end
   end

   assign bus.tl_d_o = tl_d_o;
   assign bus.tl_h_o = tl_h_o;

   tlul_arb_idx_fifo #(
      .Width (IdxW),
      .Depth (MaxOutstanding)
   ) u_idx_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (accept),
      .wdata  (winner),
      .pop    (pop),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (outstanding_o),
      .rdata  (head)
   );

endmodule

// File: doc/tlul_periph_host_arb.md
Name: tlul_periph_host_arb

Overview:
- Shares the single peripheral-bus TL-UL host port among N requesters (core LSU, DMA, debug) ahead of the peripheral crossbar.
- Arbitrates A-channel requests round-robin.
- Records the issuing host of every accepted request in an in-order tracking FIFO.
- Steers each D-channel response back to that host.
- Relies on in-order responses downstream: the 1:N socket serialises per-device outstanding requests.

Parameters:
- N, 2, number of upstream hosts (2..8).
- MaxOutstanding, 4, depth of the host-ID tracking FIFO (power of two, 2..16).
- IdxW, $clog2(N) (min 1), width of host index; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- tl_h_i  in  tlul_h2d_t[N]  requests from hosts; index 0 = highest initial priority.
- tl_h_o  out  tlul_d2h_t[N]  responses/a_ready to hosts.
- tl_d_o  out  tlul_h2d_t  request to peripheral crossbar.
- tl_d_i  in  tlul_d2h_t  response from peripheral crossbar.
- outstanding_o  out  $clog2(MaxOutstanding)+1  current tracking-FIFO occupancy.
- err_spurious_o  out  1  one-cycle pulse: D beat received with empty tracking FIFO.

Behaviour:
- Reset:
  - rr_ptr=0, FIFO empty, outstanding_o=0, err_spurious_o=0.
  - tl_d_o.a_valid=0, tl_d_o.d_ready=0, all tl_h_o.a_ready=0, all tl_h_o.d_valid=0.
- Arbitration (combinational, no added latency):
  - winner = first host with a_valid scanning from rr_ptr upward, wrapping modulo N.
  - tl_d_o carries the winner's A fields; a_valid = winner valid AND FIFO not full.
  - Winner's a_ready = tl_d_i.a_ready AND FIFO not full; all other hosts see a_ready=0.
- Grant stability: if the forwarded a_valid is high and a_ready is low, the registered grant locks to that host until acceptance. A later request from a higher-priority host must not change tl_d_o mid-handshake.
- Accept (tl_d_o.a_valid & tl_d_i.a_ready):
  - push winner index into FIFO.
  - rr_ptr <= (winner+1) mod N.
  - release lock.
- Full: at occupancy MaxOutstanding, no A beat is forwarded, even if a pop occurs in the same cycle (no bypass).
- Response routing:
  - head = FIFO head index.
  - tl_h_o[head] gets tl_d_i D fields with d_valid; all other hosts see d_valid=0.
  - tl_d_o.d_ready = tl_h_i[head].d_ready.
  - pop on d_valid & d_ready.
- Simultaneous push and pop: occupancy unchanged; pointers both advance.
- Spurious response: D beat arrives with FIFO empty → d_ready=1 (beat drained), no host sees d_valid, err_spurious_o=1 for that cycle.
- Same-cycle request/response to one host: independent channels, both proceed.
- Zero-latency response (D beat in the cycle after accept) must route correctly; the FIFO write is visible next cycle.
- Reset mid-transaction: all state clears asynchronously. Responses still in flight downstream afterwards are treated as spurious.
- Unused A fields pass through unmodified; a_source is not altered.

Decomposition:
- Package tlul_periph_arb_pkg holds:
  - MaxHostsDefault, MaxOutstandingDefault.
  - function rr_pick(req, ptr) returning the winner index.
- Sub-module tlul_arb_idx_fifo: synchronous FIFO of IdxW-bit entries, depth MaxOutstanding.
  - Ports: push/pop/full/empty/count/rdata.
  - Asynchronous active-low reset.
- The arbiter instantiates one tlul_arb_idx_fifo.

Test Plan:
- Host0 and host1 assert a_valid together from reset with a_ready=1 → host0 accepted cycle 0, host1 cycle 1, host0 cycle 2 (alternating); outstanding_o climbs to 3 with no D traffic.
- a_ready held 0 for 5 cycles while host1 is granted and host0 raises a_valid at cycle 2 → tl_d_o stays host1's address throughout; host1 accepted when a_ready=1.
- 4 accepts with no D beats (MaxOutstanding=4) → 5th request gets a_ready=0 and tl_d_o.a_valid=0. One D beat pops → next cycle 5th request accepted; outstanding_o = 4.
- Issue order h1,h0,h1 with read data 0x11,0x22,0x33 returned in order → host1 gets 0x11, host0 0x22, host1 0x33; the other host never sees d_valid.
- D beat injected with FIFO empty → err_spurious_o pulses one cycle, tl_d_o.d_ready=1, no host d_valid.
- rst_ni asserted with outstanding_o=2 → all outputs return to reset values asynchronously; the subsequent late D beat flags err_spurious_o.
